// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, register-index/word types and architectural
// register names for the MIPS pipeline core.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_regfile_rdport.sv
// mips_regfile_rdport: one combinational read port of the register file.
// Forces index 0 to zero and forwards the in-flight WB write when the
// indices match, so a same-cycle write is visible before it commits.
// Ports:
//   i_rd_num     read index
//   i_reg_data   stored contents of regs[i_rd_num]
//   i_byp_vld    a committing write is present this cycle (non-zero index, no reset)
//   i_wr_num     write index
//   i_wr_data    write data
//   o_rd_data_c  resolved read data (combinational)
module mips_regfile_rdport
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] i_rd_num,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_byp_vld,
    input  logic [ADDR_W-1:0] i_wr_num,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data_c
);

    // Zero register wins over bypass; bypass wins over stored state.
    always_comb begin
        o_rd_data_c = i_reg_data;
        if (i_rd_num == '0) begin
            o_rd_data_c = '0;
        end else if (i_byp_vld && (i_wr_num == i_rd_num)) begin
            o_rd_data_c = i_wr_data;
        end
    end

endmodule : mips_regfile_rdport

// File: rtl/mips_regfile.sv
// mips_regfile: 32-entry GPR file, two combinational read ports, one
// synchronous write port with write-to-read bypass. Register 0 reads zero.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high clear of all registers (beats a write)
//   wr_num    write index
//   wr_data   write data
//   wr_en     write enable
//   rd0_num   read port 0 index
//   rd0_data  read port 0 data (combinational)
//   rd1_num   read port 1 index
//   rd1_data  read port 1 data (combinational)
module mips_regfile
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_num,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd0_num,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [ADDR_W-1:0] rd1_num,
    output logic [DATA_W-1:0] rd1_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_wr_commit;
    logic [DATA_W-1:0] w_rd0_reg;
    logic [DATA_W-1:0] w_rd1_reg;

    // A write only lands (and only bypasses) when not in reset and not to r0.
    assign w_wr_commit = !reset && wr_en && (wr_num != '0);

    // Storage; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_commit) begin
            r_regs[wr_num] <= wr_data;
        end
    end

    assign w_rd0_reg = r_regs[rd0_num];
    assign w_rd1_reg = r_regs[rd1_num];

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport0 (
        .i_rd_num    (rd0_num),
        .i_reg_data  (w_rd0_reg),
        .i_byp_vld   (w_wr_commit),
        .i_wr_num    (wr_num),
        .i_wr_data   (wr_data),
        .o_rd_data_c (rd0_data)
    );

    mips_regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rdport1 (
        .i_rd_num    (rd1_num),
        .i_reg_data  (w_rd1_reg),
        .i_byp_vld   (w_wr_commit),
        .i_wr_num    (wr_num),
        .i_wr_data   (wr_data),
        .o_rd_data_c (rd1_data)
    );

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// tb_mips_regfile: scoreboard bench for mips_regfile. Each cycle the
// expected read values are pushed when inputs are driven and popped and
// compared against the ports half a cycle later, before the commit edge.
module tb_mips_regfile;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [4:0]  rd0_num;
    logic [31:0] rd0_data;
    logic [4:0]  rd1_num;
    logic [31:0] rd1_data;

    int unsigned n_total;
    int unsigned n_bad;

    logic [31:0] model [32];
    logic [31:0] exp_q [$];

    mips_regfile u_dut (
        .clk      (clk),
        .reset    (reset),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .rd0_num  (rd0_num),
        .rd0_data (rd0_data),
        .rd1_num  (rd1_num),
        .rd1_data (rd1_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference read: r0 is zero, a live non-reset write to a non-zero
    // matching index is forwarded, otherwise the stored model value.
    function automatic logic [31:0] ref_read(input logic rst, input logic we,
                                             input logic [4:0] wn, input logic [31:0] wd,
                                             input logic [4:0] rn);
        if (rn == 5'd0) return 32'h0;
        if (!rst && we && (wn != 5'd0) && (wn == rn)) return wd;
        return model[rn];
    endfunction

    // Called just after a rising edge; drives one cycle, checks both ports
    // mid-cycle, then applies the edge to the model.
    task automatic do_cycle(input string tag, input logic rst, input logic we,
                            input logic [4:0] wn, input logic [31:0] wd,
                            input logic [4:0] r0n, input logic [4:0] r1n);
        logic [31:0] e;
        reset   = rst;
        wr_en   = we;
        wr_num  = wn;
        wr_data = wd;
        rd0_num = r0n;
        rd1_num = r1n;
        exp_q.push_back(ref_read(rst, we, wn, wd, r0n));
        exp_q.push_back(ref_read(rst, we, wn, wd, r1n));
        @(negedge clk);
        if (exp_q.size() < 2) begin
            chk({tag, "_queue"}, 32'(exp_q.size()), 32'd2);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rd0"}, rd0_data, e);
            e = exp_q.pop_front();
            chk({tag, "_rd1"}, rd1_data, e);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && (wn != 5'd0)) begin
            model[wn] = wd;
        end
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_num  = '0;
        wr_data = '0;
        rd0_num = '0;
        rd1_num = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Initial reset; contents before it are unknown so nothing is checked.
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state: every index on both ports reads zero.
        for (int i = 0; i < 32; i++)
            do_cycle("rst_init", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Preload r1..r31 with non-zero values (bypass checked on port 0).
        for (int i = 1; i < 32; i++)
            do_cycle("preload", 1'b0, 1'b1, 5'(i), 32'h5A000000 | (32'(i) * 32'h00010101),
                     5'(i), 5'(i - 1));

        // Reset colliding with a write: no bypass, write dropped.
        do_cycle("rst_coll", 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd3);
        for (int i = 0; i < 32; i++)
            do_cycle("rst_clr", 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Same write without reset lands.
        do_cycle("wr7", 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        do_cycle("rd7", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd6);

        // Basic write/read on sp and ra.
        do_cycle("wr_sp", 1'b0, 1'b1, REG_SP, 32'h80120000, 5'd1, 5'd2);
        do_cycle("wr_ra", 1'b0, 1'b1, REG_RA, 32'h00000000, 5'd1, 5'd2);
        do_cycle("rd_sp_ra", 1'b0, 1'b0, 5'd0, 32'h0, REG_SP, REG_RA);

        // r0 immutability.
        do_cycle("r0_wr", 1'b0, 1'b1, REG_ZERO, 32'hDEADBEEF, REG_ZERO, REG_ZERO);
        do_cycle("r0_rd", 1'b0, 1'b0, 5'd0, 32'h0, REG_ZERO, REG_ZERO);

        // Bypass on both ports.
        do_cycle("r5_set", 1'b0, 1'b1, 5'd5, 32'h11111111, 5'd4, 5'd6);
        do_cycle("r5_hold", 1'b0, 1'b0, 5'd5, 32'h22222222, 5'd5, 5'd5);
        do_cycle("r5_byp", 1'b0, 1'b1, 5'd5, 32'h22222222, 5'd5, 5'd5);
        do_cycle("r5_after", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);

        // Random regression with occasional reset.
        for (int c = 0; c < 10000; c++) begin
            do_cycle("rnd", ($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)),
                     5'($urandom), $urandom, 5'($urandom), 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mips_regfile

// File: doc/mips_regfile.md
Name: mips_regfile

Overview:
- 32-entry general-purpose register file for the 5-stage MIPS pipeline core.
- Two combinational read ports feed the ID/EX operand paths (rs, rt/rd); one synchronous write port is driven by the WB stage.
- Register 0 is hardwired to zero.
- Write-to-read bypass lets a WB write and an ID read of the same register resolve in the same cycle.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; depth = 2**ADDR_W (32).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; clears every register.
- wr_num  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- wr_en  in  1  write enable; a write commits at a rising clk edge when high.
- rd0_num  in  ADDR_W  read port 0 register index.
- rd0_data  out  DATA_W  read port 0 data (combinational).
- rd1_num  in  ADDR_W  read port 1 register index.
- rd1_data  out  DATA_W  read port 1 data (combinational).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset takes effect only at a rising clk edge while reset=1.
- Reset: at a rising edge with reset=1, all 32 registers become 0. Reset has priority over a simultaneous write, which is dropped.
- Reset outputs: after reset, rd0_data and rd1_data read 0 for any index.
- Write: at a rising edge with reset=0 and wr_en=1, regs[wr_num] <= wr_data. The new value is stored one edge after presentation.
- Writes with wr_num=0 are ignored; regs[0] stays 0 permanently.
- With wr_en=0, no register changes.
- Read: rdN_data is a function of rdN_num and current state with no clock latency. rdN_num=0 always yields 0.
- Bypass: when reset=0, wr_en=1, wr_num!=0 and wr_num==rdN_num, rdN_data = wr_data in the same cycle, before the edge commits it.
  - Both ports bypass independently.
  - There is no bypass while reset=1.
- Same-index reads: both ports reading the same index return identical data.
- Arithmetic: none. Data is stored and returned bit-exact; no sign or width conversion.
- X-handling: an X/Z index on a read port may produce X on that port only. It must not corrupt stored state.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32;
  - typedef reg_idx_t (logic [4:0]) and word_t (logic [31:0]);
  - named indices REG_ZERO=0, REG_SP=29, REG_RA=31.
- Optional single sub-module mips_regfile_rdport (index compare, zero force, bypass mux), instantiated twice. Otherwise the block is flat.

Test Plan:
- Reset clears: preload regs 1..31 with nonzero values, assert reset one edge, then sweep both read ports -> every read = 0x00000000.
- Basic write/read: write 0x80120000 to r29 and 0x00000000 to r31, then read r29 on port0 and r31 on port1 -> 0x80120000 and 0x00000000.
- r0 immutability: write 0xDEADBEEF to r0 with wr_en=1 -> both ports reading r0 return 0 before and after the edge.
- Bypass: hold r5=0x11111111, then drive wr_en=1, wr_num=5, wr_data=0x22222222 with rd0_num=rd1_num=5 -> both ports show 0x22222222 in the same cycle and after the edge.
  - With wr_en=0 the ports show 0x11111111.
- Reset vs write collision: reset=1 together with wr_en=1, wr_num=7, wr_data=0xA5A5A5A5 -> after the edge r7 reads 0.
  - The same stimulus without reset -> r7 reads 0xA5A5A5A5.
- Random regression: 10k cycles of random wr_en/indices/data checked against a 32-entry reference array including the r0 and bypass rules -> zero mismatches.
